// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage countdown scoreboard and matrix occupancy windows driving stall/flush (HAZARD_PERF_EN adds stall_raw_cnt/stall_struct_cnt/flush_cnt)
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 4,
  parameter int PA_WIN   = 3,
  parameter int M2_WIN   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic [1:0]        id_lat_class,
  input  logic              id_mtx_pa,
  input  logic              id_mtx_m2,
  input  logic              id_mtx_store,
  input  logic              br_ctrl,
  output logic              stall,
  output logic              flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic              pa_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_raw_cnt,
  output logic [31:0]       stall_struct_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [PA_WIN-1:0] pa_sr;
  logic [M2_WIN-1:0] m2_sr;
  logic [CNT_W-1:0] lat;
  logic m2_busy, raw, waw, strc, issue;
  assign lat = id_lat_class == 2'd0 ? '0 : id_lat_class == 2'd1 ? CNT_W'(LOAD_LAT) : CNT_W'(LONG_LAT);
  assign raw = (id_rs1_used && id_rs1 != '0 && cnt[id_rs1] != '0) ||
               (id_rs2_used && id_rs2 != '0 && cnt[id_rs2] != '0);
  assign waw = id_reg_write && id_rd != '0 && cnt[id_rd] > lat;
  assign pa_busy = |pa_sr;
  assign m2_busy = |m2_sr;
  assign strc = (id_mtx_store && pa_busy) || (id_mtx_pa && m2_busy);
  assign stall = id_valid && !br_ctrl && (raw || waw || strc);
  assign flush = br_ctrl;
  assign issue = id_valid && !stall && !br_ctrl;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    assign busy_vec[r] = cnt[r] != '0;
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt[r] <= '0;
      else if (r != 0 && issue && id_reg_write && id_rd == REG_AW'(r)) cnt[r] <= lat;
      else if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      pa_sr <= '0;
      m2_sr <= '0;
    end else begin
      pa_sr <= PA_WIN'({pa_sr, issue && id_mtx_pa});
      m2_sr <= M2_WIN'({m2_sr, issue && id_mtx_m2});
    end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      stall_raw_cnt    <= '0;
      stall_struct_cnt <= '0;
      flush_cnt        <= '0;
    end else begin
      if (stall && (raw || waw)) stall_raw_cnt <= stall_raw_cnt + 32'd1;
      if (stall && !(raw || waw)) stall_struct_cnt <= stall_struct_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall/flush/busy_vec/pa_busy against hand-computed values
module tb_hazard_scoreboard;
  logic clk = 0, rstn = 0;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mtx_pa, id_mtx_m2, id_mtx_store, br_ctrl;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_lat_class;
  logic stall, flush, pa_busy;
  logic [31:0] busy_vec;
  int tests = 0, fails = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_raw_cnt, stall_struct_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  hazard_scoreboard dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_lat_class(id_lat_class), .id_mtx_pa(id_mtx_pa),
    .id_mtx_m2(id_mtx_m2), .id_mtx_store(id_mtx_store), .br_ctrl(br_ctrl),
    .stall(stall), .flush(flush), .busy_vec(busy_vec), .pa_busy(pa_busy)
`ifdef HAZARD_PERF_EN
    , .stall_raw_cnt(stall_raw_cnt), .stall_struct_cnt(stall_struct_cnt), .flush_cnt(flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    {id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mtx_pa, id_mtx_m2, id_mtx_store, br_ctrl} = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_lat_class = 0;
  endtask
  task automatic wr(input logic [4:0] rd, input logic [1:0] cls);
    idle(); id_valid = 1; id_reg_write = 1; id_rd = rd; id_lat_class = cls;
  endtask
  task automatic rd1(input logic [4:0] rs);
    idle(); id_valid = 1; id_rs1_used = 1; id_rs1 = rs;
  endtask
  task automatic cyc();
    @(posedge clk); #2;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    idle();
    #3;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_pa_busy", 32'(pa_busy), 0);
    cyc(); cyc();
    rstn = 1;
    cyc();
    wr(5, 1); settle();
    chk("ld_issue_stall", 32'(stall), 0);
    cyc();
    rd1(5); id_reg_write = 1; id_rd = 6; settle();
    chk("lu_busy5", 32'(busy_vec[5]), 1);
    chk("lu_stall_t1", 32'(stall), 1);
    cyc(); settle();
    chk("lu_stall_t2", 32'(stall), 0);
    chk("lu_busy5_t2", 32'(busy_vec[5]), 0);
    cyc(); idle(); settle();
    chk("alu_no_busy", busy_vec, 0);
    wr(7, 2); cyc();
    idle(); id_valid = 1; id_rs2_used = 1; id_rs2 = 7;
    for (int k = 1; k <= 4; k++) begin
      settle(); chk($sformatf("long_stall_t%0d", k), 32'(stall), 1); cyc();
    end
    settle(); chk("long_issue_t5", 32'(stall), 0);
    cyc();
    wr(0, 1); cyc();
    rd1(0); settle();
    chk("x0_busy", busy_vec, 0);
    chk("x0_stall", 32'(stall), 0);
    cyc();
    wr(3, 2); cyc();
    wr(3, 0);
    for (int k = 1; k <= 3; k++) begin
      settle(); chk($sformatf("waw_stall_t%0d", k), 32'(stall), 1); cyc();
    end
    settle(); chk("waw_alu_t4", 32'(stall), 1);
    wr(3, 1); settle();
    chk("waw_load_t4", 32'(stall), 0);
    cyc(); idle(); settle();
    chk("waw_load_busy", busy_vec, 32'h8);
    cyc(); settle();
    chk("waw_drained", busy_vec, 0);
    idle(); id_valid = 1; id_mtx_pa = 1; cyc();
    idle(); id_valid = 1; id_mtx_store = 1;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk($sformatf("pa_st_stall_t%0d", k), 32'(stall), 1);
      chk($sformatf("pa_busy_t%0d", k), 32'(pa_busy), 1);
      cyc();
    end
    settle();
    chk("pa_st_issue_t4", 32'(stall), 0);
    chk("pa_busy_t4", 32'(pa_busy), 0);
    cyc();
    idle(); id_valid = 1; id_mtx_m2 = 1; cyc();
    idle(); id_valid = 1; id_mtx_pa = 1; settle();
    chk("m2_pa_stall_t1", 32'(stall), 1);
    chk("m2_pa_busy_t1", 32'(pa_busy), 0);
    cyc(); settle();
    chk("m2_pa_stall_t2", 32'(stall), 1);
    cyc(); settle();
    chk("m2_pa_issue_t3", 32'(stall), 0);
    cyc(); idle(); settle();
    chk("pa_after_issue", 32'(pa_busy), 1);
    cyc(); cyc(); cyc(); settle();
    chk("pa_drained", 32'(pa_busy), 0);
    wr(9, 1); cyc();
    rd1(9); id_reg_write = 1; id_rd = 10; id_lat_class = 2; br_ctrl = 1; settle();
    chk("br_stall", 32'(stall), 0);
    chk("br_flush", 32'(flush), 1);
    cyc(); idle(); settle();
    chk("br_no_record", busy_vec, 0);
    chk("br_flush_off", 32'(flush), 0);
    wr(12, 2); cyc(); idle(); settle();
    chk("pre_rst_busy", busy_vec, 32'h1000);
    rstn = 0; #1;
    chk("async_rst_busy", busy_vec, 0);
    #1; rstn = 1;
    cyc(); settle();
    chk("post_rst_busy", busy_vec, 0);
    for (int k = 0; k < 3; k++) begin
      wr(5'(k + 1), 1); cyc();
      rd1(5'(k + 1)); settle();
      chk($sformatf("perf_lu_stall%0d", k), 32'(stall), 1);
      cyc(); cyc(); idle();
    end
    br_ctrl = 1; cyc(); cyc(); idle(); settle();
`ifdef HAZARD_PERF_EN
    chk("perf_raw", stall_raw_cnt, 3);
    chk("perf_struct", stall_struct_cnt, 0);
    chk("perf_flush", flush_cnt, 2);
`endif
    chk("end_busy", busy_vec, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
